// File: rtl/leitor_caminho.sv
// Path reader: loads obstacles into the accelerator, launches a search, captures the
// node stream (destino back to fonte) and replays it to the host in fonte-first order.
module leitor_caminho #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DEPTH         = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    host_start_in,
  input  logic [ADDR_WIDTH-1:0]   host_fonte_in,
  input  logic [ADDR_WIDTH-1:0]   host_destino_in,

  input  logic                    host_obst_valid_in,
  input  logic [ADDR_WIDTH-1:0]   host_obst_addr_in,
  input  logic                    host_obst_data_in,
  output logic                    host_obst_ready_out,

  output logic [ADDR_WIDTH-1:0]   top_addr_fonte_out,
  output logic [ADDR_WIDTH-1:0]   top_addr_destino_out,
  output logic                    top_wr_fonte_out,

  output logic                    obstaculos_wr_enable_out,
  output logic [ADDR_WIDTH-1:0]   obstaculos_wr_addr_out,
  output logic                    obstaculos_wr_data_out,

  input  logic [ADDR_WIDTH-1:0]   gma_read_data_in,
  input  logic                    gma_pronto_in,

  output logic                    path_valid_out,
  output logic [ADDR_WIDTH-1:0]   path_data_out,
  output logic                    path_last_out,
  input  logic                    path_ready_in,

  output logic                    busy_out,
  output logic                    erro_overflow_out,
  output logic                    erro_timeout_out,
  output logic [$clog2(DEPTH):0]  path_len_out
);

  // state    | meaning
  // OCIOSO   | idle, accepts obstacles and start requests
  // INICIA   | one-cycle start strobe to the accelerator
  // AGUARDA  | waiting for the first path node, timeout running
  // CAPTURA  | storing the node stream into the path buffer
  // ENTREGA  | replaying the buffer to the host, newest node first
  typedef enum logic [2:0] {OCIOSO, INICIA, AGUARDA, CAPTURA, ENTREGA} estado_t;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [IW-1:0] IDX_ONE  = 1;
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = 1;
  // Value seen on the last wait cycle: the increment taken here would make the counter all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  estado_t                  state_q;
  logic [ADDR_WIDTH-1:0]    fonte_q;
  logic [ADDR_WIDTH-1:0]    destino_q;
  logic                     top_wr_q;
  logic                     busy_q;
  logic                     valid_q;
  logic                     obst_we_q;
  logic [ADDR_WIDTH-1:0]    obst_addr_q;
  logic                     obst_data_q;
  logic [CW-1:0]            count_q;
  logic [IW-1:0]            idx_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  logic                     ovf_q;
  logic                     tmo_err_q;

  logic [ADDR_WIDTH-1:0]    buf_q [DEPTH];

  logic                     has_room;
  logic [IW-1:0]            cnt_lo;
  logic                     cap_we;
  logic [IW-1:0]            cap_waddr;
  logic [IW-1:0]            last_idx;
  logic                     node_is_fonte;

  assign has_room      = (count_q < CNT_FULL);
  assign cnt_lo        = count_q[IW-1:0];
  assign node_is_fonte = (gma_read_data_in == fonte_q);

  always_comb begin
    cap_we    = 1'b0;
    cap_waddr = '0;
    if (gma_pronto_in) begin
      if (state_q == AGUARDA) begin
        cap_we = 1'b1;
      end else if ((state_q == CAPTURA) && has_room) begin
        cap_we    = 1'b1;
        cap_waddr = cnt_lo;
      end
    end
  end

  // Index of the newest stored node once this cycle's write (if any) has landed.
  assign last_idx = cap_we ? cnt_lo : (cnt_lo - IDX_ONE);

  always_ff @(posedge clk) begin
    if (cap_we) begin
      buf_q[cap_waddr] <= gma_read_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCIOSO;
      fonte_q     <= '0;
      destino_q   <= '0;
      top_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      obst_we_q   <= 1'b0;
      obst_addr_q <= '0;
      obst_data_q <= 1'b0;
      count_q     <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      ovf_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      obst_we_q <= 1'b0;
      top_wr_q  <= 1'b0;
      case (state_q)
        OCIOSO: begin
          if (host_start_in) begin
            fonte_q   <= host_fonte_in;
            destino_q <= host_destino_in;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
            top_wr_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= INICIA;
          end else if (host_obst_valid_in) begin
            obst_addr_q <= host_obst_addr_in;
            obst_data_q <= host_obst_data_in;
            obst_we_q   <= 1'b1;
          end
        end
        INICIA: begin
          tmo_q   <= '0;
          state_q <= AGUARDA;
        end
        AGUARDA: begin
          if (gma_pronto_in) begin
            count_q <= CNT_ONE;
            if (node_is_fonte) begin
              idx_q   <= '0;
              valid_q <= 1'b1;
              state_q <= ENTREGA;
            end else begin
              state_q <= CAPTURA;
            end
          end else if (tmo_q == TMO_LAST) begin
            tmo_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= OCIOSO;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        CAPTURA: begin
          if (gma_pronto_in) begin
            if (has_room) begin
              count_q <= count_q + CNT_ONE;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (!gma_pronto_in || node_is_fonte) begin
            idx_q   <= last_idx;
            valid_q <= 1'b1;
            state_q <= ENTREGA;
          end
        end
        ENTREGA: begin
          if (path_ready_in) begin
            if (idx_q == '0) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= OCIOSO;
            end else begin
              idx_q <= idx_q - IDX_ONE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= OCIOSO;
        end
      endcase
    end
  end

  assign host_obst_ready_out      = (state_q == OCIOSO) && !host_start_in;
  assign top_addr_fonte_out       = fonte_q;
  assign top_addr_destino_out     = destino_q;
  assign top_wr_fonte_out         = top_wr_q;
  assign obstaculos_wr_enable_out = obst_we_q;
  assign obstaculos_wr_addr_out   = obst_addr_q;
  assign obstaculos_wr_data_out   = obst_data_q;
  assign path_valid_out           = valid_q;
  assign path_data_out            = valid_q ? buf_q[idx_q] : '0;
  assign path_last_out            = valid_q && (idx_q == '0);
  assign busy_out                 = busy_q;
  assign erro_overflow_out        = ovf_q;
  assign erro_timeout_out         = tmo_err_q;
  assign path_len_out             = count_q;

endmodule

// File: tb/tb_leitor_caminho.sv
// Self-checking bench for leitor_caminho: directed scenarios plus randomized searches,
// checked against a queue-based model of the expected path and obstacle writes.
module tb_leitor_caminho;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_start_in;
  logic [AW-1:0] host_fonte_in, host_destino_in;
  logic          host_obst_valid_in;
  logic [AW-1:0] host_obst_addr_in;
  logic          host_obst_data_in;
  logic          host_obst_ready_out;
  logic [AW-1:0] top_addr_fonte_out, top_addr_destino_out;
  logic          top_wr_fonte_out;
  logic          obstaculos_wr_enable_out;
  logic [AW-1:0] obstaculos_wr_addr_out;
  logic          obstaculos_wr_data_out;
  logic [AW-1:0] gma_read_data_in;
  logic          gma_pronto_in;
  logic          path_valid_out;
  logic [AW-1:0] path_data_out;
  logic          path_last_out;
  logic          path_ready_in;
  logic          busy_out, erro_overflow_out, erro_timeout_out;
  logic [$clog2(DEPTH):0] path_len_out;

  leitor_caminho #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_start_in(host_start_in), .host_fonte_in(host_fonte_in), .host_destino_in(host_destino_in),
    .host_obst_valid_in(host_obst_valid_in), .host_obst_addr_in(host_obst_addr_in),
    .host_obst_data_in(host_obst_data_in), .host_obst_ready_out(host_obst_ready_out),
    .top_addr_fonte_out(top_addr_fonte_out), .top_addr_destino_out(top_addr_destino_out),
    .top_wr_fonte_out(top_wr_fonte_out),
    .obstaculos_wr_enable_out(obstaculos_wr_enable_out), .obstaculos_wr_addr_out(obstaculos_wr_addr_out),
    .obstaculos_wr_data_out(obstaculos_wr_data_out),
    .gma_read_data_in(gma_read_data_in), .gma_pronto_in(gma_pronto_in),
    .path_valid_out(path_valid_out), .path_data_out(path_data_out), .path_last_out(path_last_out),
    .path_ready_in(path_ready_in),
    .busy_out(busy_out), .erro_overflow_out(erro_overflow_out), .erro_timeout_out(erro_timeout_out),
    .path_len_out(path_len_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  bit rdy_rand = 1'b0;

  // Model state: beats still owed to the host, obstacle writes still owed to the accelerator.
  logic [AW-1:0] exp_beats [$];
  logic [AW:0]   exp_obst  [$];
  int            exp_len;
  bit            exp_ovf;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endfunction

  // The host sees the first DEPTH stored nodes, newest first.
  function automatic void push_expect(input logic [AW-1:0] nodes [$]);
    int n;
    n = (nodes.size() > DEPTH) ? DEPTH : nodes.size();
    for (int i = n - 1; i >= 0; i--) exp_beats.push_back(nodes[i]);
    exp_len = n;
    exp_ovf = (nodes.size() > DEPTH);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (path_valid_out) begin
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", path_valid_out, 0);
        end else begin
          chk("beat_data", path_data_out, exp_beats[0]);
          chk("beat_last", path_last_out, exp_beats.size() == 1);
          chk("busy_during_beat", busy_out, 1);
          if (path_ready_in) begin
            void'(exp_beats.pop_front());
            beats_seen++;
          end
        end
      end
      if (obstaculos_wr_enable_out) begin
        if (exp_obst.size() == 0) begin
          chk("obst_unexpected", obstaculos_wr_enable_out, 0);
        end else begin
          chk("obst_addr", obstaculos_wr_addr_out, exp_obst[0][AW-1:0]);
          chk("obst_data", obstaculos_wr_data_out, exp_obst[0][AW]);
          void'(exp_obst.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) path_ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] d);
    step();
    host_start_in = 1'b1;
    host_fonte_in = f;
    host_destino_in = d;
    @(negedge clk);
    chk("obst_ready_with_start", host_obst_ready_out, 0);
    step();
    host_start_in = 1'b0;
    host_fonte_in = AW'($urandom);
    host_destino_in = AW'($urandom);
    @(negedge clk);
    chk("start_wr_fonte", top_wr_fonte_out, 1);
    chk("start_addr_fonte", top_addr_fonte_out, f);
    chk("start_addr_destino", top_addr_destino_out, d);
    chk("start_busy", busy_out, 1);
    chk("start_len_clr", path_len_out, 0);
    chk("start_ovf_clr", erro_overflow_out, 0);
    chk("start_tmo_clr", erro_timeout_out, 0);
  endtask

  task automatic stream(input logic [AW-1:0] nodes [$], input int gap);
    repeat (gap) step();
    foreach (nodes[i]) begin
      gma_pronto_in = 1'b1;
      gma_read_data_in = nodes[i];
      step();
    end
    gma_pronto_in = 1'b0;
    gma_read_data_in = AW'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_out) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (path_valid_out) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("valid_reached", ok, 1);
  endtask

  task automatic obst_burst(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      host_obst_valid_in = 1'($urandom_range(0, 1));
      host_obst_addr_in = AW'($urandom);
      host_obst_data_in = 1'($urandom_range(0, 1));
      if (host_obst_valid_in) exp_obst.push_back({host_obst_data_in, host_obst_addr_in});
    end
    step();
    host_obst_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] q [$];
    logic [AW-1:0] f, d, x;
    int n, b0;

    rst_n = 1'b0;
    host_start_in = 1'b0; host_fonte_in = '0; host_destino_in = '0;
    host_obst_valid_in = 1'b0; host_obst_addr_in = '0; host_obst_data_in = 1'b0;
    gma_read_data_in = '0; gma_pronto_in = 1'b0; path_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_obst_ready", host_obst_ready_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_valid", path_valid_out, 0);
    chk("rst_wr_fonte", top_wr_fonte_out, 0);
    chk("rst_wr_enable", obstaculos_wr_enable_out, 0);
    chk("rst_len", path_len_out, 0);
    chk("rst_errors", {erro_overflow_out, erro_timeout_out}, 0);
    chk("rst_addr_fonte", top_addr_fonte_out, 0);
    step();
    rst_n = 1'b1;

    // single obstacle write
    step();
    host_obst_valid_in = 1'b1; host_obst_addr_in = 8'h12; host_obst_data_in = 1'b1;
    exp_obst.push_back({1'b1, 8'h12});
    @(negedge clk);
    chk("obst_ready_idle", host_obst_ready_out, 1);
    chk("obst_we_before", obstaculos_wr_enable_out, 0);
    step();
    host_obst_valid_in = 1'b0;
    @(negedge clk);
    chk("obst_we_pulse", obstaculos_wr_enable_out, 1);
    chk("obst_addr_12", obstaculos_wr_addr_out, 8'h12);
    chk("obst_data_1", obstaculos_wr_data_out, 1);
    @(negedge clk);
    chk("obst_we_one_cycle", obstaculos_wr_enable_out, 0);

    // basic path with a 3-cycle stall after the first beat
    rdy_rand = 1'b0;
    path_ready_in = 1'b0;
    do_start(8'h01, 8'h05);
    q = '{8'h05, 8'h04, 8'h02, 8'h01};
    push_expect(q);
    chk("model_beat0", exp_beats[0], 8'h01);
    chk("model_beat3", exp_beats[3], 8'h05);
    stream(q, 2);
    wait_valid();
    chk("first_beat_fonte", path_data_out, 8'h01);
    chk("first_beat_not_last", path_last_out, 0);
    step();
    path_ready_in = 1'b1;
    step();
    path_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", path_data_out, 8'h02);
      step();
    end
    path_ready_in = 1'b1;
    wait_idle();
    chk("path_len_4", path_len_out, 4);
    chk("path_no_ovf", erro_overflow_out, 0);
    chk("path_beats_all", exp_beats.size(), 0);

    // overflow: six nodes into a four-entry buffer
    rdy_rand = 1'b1;
    b0 = beats_seen;
    do_start(8'h10, 8'h20);
    q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h10};
    push_expect(q);
    chk("model_ovf_beat0", exp_beats[0], 8'h23);
    chk("model_ovf", exp_ovf, 1);
    stream(q, 3);
    wait_idle();
    chk("ovf_flag", erro_overflow_out, 1);
    chk("ovf_len", path_len_out, 4);
    chk("ovf_beats", beats_seen - b0, 4);

    // start and obstacle in the same cycle, followed by a timeout
    step();
    host_start_in = 1'b1; host_fonte_in = 8'h44; host_destino_in = 8'h55;
    host_obst_valid_in = 1'b1; host_obst_addr_in = 8'h33; host_obst_data_in = 1'b1;
    @(negedge clk);
    chk("collide_ready", host_obst_ready_out, 0);
    step();
    host_start_in = 1'b0; host_obst_valid_in = 1'b0;
    @(negedge clk);
    chk("collide_wr_fonte", top_wr_fonte_out, 1);
    chk("collide_no_obst", obstaculos_wr_enable_out, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_out) break;
      n++;
      if (n == 1) chk("wr_fonte_one_cycle", top_wr_fonte_out, 0);
    end
    chk("timeout_wait_cycles", n, 15);
    chk("timeout_flag", erro_timeout_out, 1);
    chk("timeout_valid", path_valid_out, 0);

    // randomized searches interleaved with obstacle bursts
    rdy_rand = 1'b1;
    for (int it = 0; it < 20; it++) begin
      obst_burst($urandom_range(0, 5));
      f = AW'($urandom);
      do d = AW'($urandom); while (d == f);
      q = '{d};
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        do x = AW'($urandom); while (x == f);
        q.push_back(x);
      end
      q.push_back(f);
      do_start(f, d);
      push_expect(q);
      stream(q, $urandom_range(1, 15));
      wait_idle();
      chk("rnd_len", path_len_out, exp_len);
      chk("rnd_ovf", erro_overflow_out, exp_ovf);
      chk("rnd_tmo", erro_timeout_out, 0);
      chk("rnd_beats_left", exp_beats.size(), 0);
    end

    // reset during delivery aborts and nothing is replayed
    rdy_rand = 1'b0;
    path_ready_in = 1'b0;
    do_start(8'h03, 8'h09);
    q = '{8'h09, 8'h07, 8'h03};
    push_expect(q);
    stream(q, 1);
    wait_valid();
    step();
    rst_n = 1'b0;
    exp_beats.delete();
    @(negedge clk);
    chk("midrst_valid", path_valid_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_obst_ready", host_obst_ready_out, 1);
    chk("midrst_len", path_len_out, 0);
    chk("midrst_data", path_data_out, 0);
    step();
    rst_n = 1'b1;
    rdy_rand = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("postrst_idle", busy_out, 0);
    chk("obst_all_written", exp_obst.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
